// File: rtl/bra_rs_pkg.sv
// bra_rs_pkg: shared types and helpers for the branch reservation station.
//
// Supplies fallback values for the shared op/tag macros normally provided by
// defines.vh (BRA_OP_WIDTH, ROB_ENTRY_WIDTH, BEQ..JALR), the entry and
// dispatch record layouts, and the CDB operand-capture helper used both for
// the allocate-time bypass and for snooping resident entries.
//
// Optional feature macro used by the block: BRA_RS_OLDEST_FIRST_EN.

`ifndef BRA_OP_WIDTH
`define BRA_OP_WIDTH 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef BEQ
`define BEQ  4'd1
`endif
`ifndef BNE
`define BNE  4'd2
`endif
`ifndef BLT
`define BLT  4'd3
`endif
`ifndef BGE
`define BGE  4'd4
`endif
`ifndef BLTU
`define BLTU 4'd5
`endif
`ifndef BGEU
`define BGEU 4'd6
`endif
`ifndef JAL
`define JAL  4'd7
`endif
`ifndef JALR
`define JALR 4'd8
`endif

package bra_rs_pkg;

  localparam int unsigned OP_W  = `BRA_OP_WIDTH;
  localparam int unsigned TAG_W = `ROB_ENTRY_WIDTH;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [TAG_W-1:0] tag_t;

  // One source operand: either waiting on tag, or holding val.
  typedef struct packed {
    logic        busy;
    tag_t        tag;
    logic [31:0] val;
  } opnd_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    opnd_t       j;
    opnd_t       k;
    logic [31:0] pc;
    logic [31:0] offset;
    tag_t        dest;
  } rs_entry_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] pc;
    logic [31:0] offset;
    tag_t        dest;
  } disp_t;

  // Capture a broadcast result into an operand still waiting on that tag.
  function automatic opnd_t snoop(input opnd_t       o,
                                  input logic        cdb_v,
                                  input tag_t        cdb_tag,
                                  input logic [31:0] cdb_val);
    snoop = o;
    if (o.busy && cdb_v && (o.tag == cdb_tag)) begin
      snoop.busy = 1'b0;
      snoop.val  = cdb_val;
    end
  endfunction

endpackage

// File: rtl/bra_rs_select.sv
// bra_rs_select: combinational dispatch arbiter for bra_rs.
//
// Ports:
//   i_ready       ready vector, one bit per entry
//   i_older       (BRA_RS_OLDEST_FIRST_EN only) row i flags entries older than i
//   o_grant       one-hot grant (all zero when nothing is ready)
//   o_grant_valid at least one entry is ready
//
// With BRA_RS_OLDEST_FIRST_EN the oldest ready entry wins; otherwise the
// lowest-index ready entry wins.

module bra_rs_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]            i_ready,
`ifdef BRA_RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
`endif
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_grant_valid
);

`ifdef BRA_RS_OLDEST_FIRST_EN
  // Ages among valid entries form a total order, so exactly one ready entry
  // has no older ready entry.
  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i] && ((i_older[i] & i_ready) == '0);
    end
  end
`else
  // Isolate the lowest set bit.
  assign o_grant = i_ready & (~i_ready + DEPTH'(1));
`endif

  assign o_grant_valid = |i_ready;

endmodule

// File: rtl/bra_rs.sv
// bra_rs: branch reservation station.
//
// Holds up to DEPTH branch/jump micro-ops until both operands are available,
// snoops the CDB for outstanding tags, and dispatches one ready micro-op per
// cycle into a registered disp_* interface feeding the branch unit.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill all entries and the pending dispatch
//   alloc_*               issue-side allocation request / alloc_ready
//   cdb_valid/tag/value   common data bus broadcast
//   disp_*                dispatched micro-op (disp_op == 0 means idle)
//
// Build option: BRA_RS_OLDEST_FIRST_EN selects oldest-first dispatch using a
// DEPTH x DEPTH age matrix; otherwise lowest-index-first with no age state.

module bra_rs
  import bra_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [`BRA_OP_WIDTH-1:0]    alloc_op,
  input  logic                        alloc_qj_busy,
  input  logic                        alloc_qk_busy,
  input  logic [`ROB_ENTRY_WIDTH-1:0] alloc_qj,
  input  logic [`ROB_ENTRY_WIDTH-1:0] alloc_qk,
  input  logic [31:0]                 alloc_vj,
  input  logic [31:0]                 alloc_vk,
  input  logic [31:0]                 alloc_pc,
  input  logic [31:0]                 alloc_offset,
  input  logic [`ROB_ENTRY_WIDTH-1:0] alloc_dest,
  input  logic                        cdb_valid,
  input  logic [`ROB_ENTRY_WIDTH-1:0] cdb_tag,
  input  logic [31:0]                 cdb_value,
  output logic [`BRA_OP_WIDTH-1:0]    disp_op,
  output logic [31:0]                 disp_srca,
  output logic [31:0]                 disp_srcb,
  output logic [31:0]                 disp_pc,
  output logic [31:0]                 disp_offset,
  output logic [`ROB_ENTRY_WIDTH-1:0] disp_dest
);

  rs_entry_t        r_ent [DEPTH];
  rs_entry_t        w_nxt [DEPTH];
  rs_entry_t        w_new;
  rs_entry_t        w_sel;
  disp_t            r_disp;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_free_oh;
  logic [DEPTH-1:0] w_grant;
  logic             w_grant_valid;
  logic             w_alloc_fire;

  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_ready[i] = r_ent[i].valid && !r_ent[i].j.busy && !r_ent[i].k.busy;
    end
  end

  // Lowest-index free slot: lowest zero bit of the valid vector.
  assign w_free_oh    = ~w_valid & (w_valid + DEPTH'(1));
  assign alloc_ready  = ~&w_valid;
  assign w_alloc_fire = alloc_valid && alloc_ready && !flush;

  // New entry, with the same-cycle CDB result bypassed into busy operands.
  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.op     = alloc_op;
    w_new.j      = snoop('{busy: alloc_qj_busy, tag: alloc_qj, val: alloc_vj},
                         cdb_valid, cdb_tag, cdb_value);
    w_new.k      = snoop('{busy: alloc_qk_busy, tag: alloc_qk, val: alloc_vk},
                         cdb_valid, cdb_tag, cdb_value);
    w_new.pc     = alloc_pc;
    w_new.offset = alloc_offset;
    w_new.dest   = alloc_dest;
  end

`ifdef BRA_RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0] r_older;

  // Row i marks entries older than i. Clearing column a on reallocation
  // removes stale "a is older" marks left behind when a was last freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_older <= '0;
    end else if (flush) begin
      r_older <= '0;
    end else if (w_alloc_fire) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (w_free_oh[a]) begin
          r_older[a] <= w_valid;
          for (int unsigned k = 0; k < DEPTH; k++) begin
            r_older[k][a] <= 1'b0;
          end
        end
      end
    end
  end
`endif

  bra_rs_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .i_ready       (w_ready),
`ifdef BRA_RS_OLDEST_FIRST_EN
    .i_older       (r_older),
`endif
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_sel = r_ent[i];
    end
  end

  // The allocation slot is free in the current cycle and the granted slot is
  // valid, so they never coincide.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
      if (flush) begin
        w_nxt[i].valid = 1'b0;
      end else if (w_alloc_fire && w_free_oh[i]) begin
        w_nxt[i] = w_new;
      end else if (w_grant[i]) begin
        w_nxt[i].valid = 1'b0;
      end else if (r_ent[i].valid) begin
        w_nxt[i].j = snoop(r_ent[i].j, cdb_valid, cdb_tag, cdb_value);
        w_nxt[i].k = snoop(r_ent[i].k, cdb_valid, cdb_tag, cdb_value);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_nxt[i];
      end
    end
  end

  // Only op is cleared when idle; the data fields hold their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
    end else if (flush) begin
      r_disp.op <= '0;
    end else if (w_grant_valid) begin
      r_disp.op     <= w_sel.op;
      r_disp.srca   <= w_sel.j.val;
      r_disp.srcb   <= w_sel.k.val;
      r_disp.pc     <= w_sel.pc;
      r_disp.offset <= w_sel.offset;
      r_disp.dest   <= w_sel.dest;
    end else begin
      r_disp.op <= '0;
    end
  end

  assign disp_op     = r_disp.op;
  assign disp_srca   = r_disp.srca;
  assign disp_srcb   = r_disp.srcb;
  assign disp_pc     = r_disp.pc;
  assign disp_offset = r_disp.offset;
  assign disp_dest   = r_disp.dest;

endmodule

// File: tb/tb_bra_rs.sv
// tb_bra_rs: self-checking bench for bra_rs (directed steps, then random
// traffic) against a behavioural model that tracks entries by slot with an
// allocation sequence number for age.

`ifndef BRA_OP_WIDTH
`define BRA_OP_WIDTH 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef BEQ
`define BEQ  4'd1
`endif
`ifndef BNE
`define BNE  4'd2
`endif
`ifndef BLT
`define BLT  4'd3
`endif
`ifndef BGE
`define BGE  4'd4
`endif
`ifndef BLTU
`define BLTU 4'd5
`endif
`ifndef BGEU
`define BGEU 4'd6
`endif
`ifndef JAL
`define JAL  4'd7
`endif
`ifndef JALR
`define JALR 4'd8
`endif

module tb_bra_rs;

  localparam int DEPTH = 4;
  localparam int OW    = `BRA_OP_WIDTH;
  localparam int TW    = `ROB_ENTRY_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [OW-1:0] alloc_op = '0;
  logic          alloc_qj_busy = 1'b0;
  logic          alloc_qk_busy = 1'b0;
  logic [TW-1:0] alloc_qj = '0;
  logic [TW-1:0] alloc_qk = '0;
  logic [31:0]   alloc_vj = '0;
  logic [31:0]   alloc_vk = '0;
  logic [31:0]   alloc_pc = '0;
  logic [31:0]   alloc_offset = '0;
  logic [TW-1:0] alloc_dest = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [31:0]   cdb_value = '0;
  logic [OW-1:0] disp_op;
  logic [31:0]   disp_srca, disp_srcb, disp_pc, disp_offset;
  logic [TW-1:0] disp_dest;

  bra_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_qj_busy(alloc_qj_busy), .alloc_qk_busy(alloc_qk_busy),
    .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .alloc_pc(alloc_pc), .alloc_offset(alloc_offset), .alloc_dest(alloc_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .disp_op(disp_op), .disp_srca(disp_srca), .disp_srcb(disp_srcb),
    .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_dest(disp_dest)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit            v;
    logic [OW-1:0] op;
    bit            jb;
    logic [TW-1:0] qj;
    logic [31:0]   vj;
    bit            kb;
    logic [TW-1:0] qk;
    logic [31:0]   vk;
    logic [31:0]   pc;
    logic [31:0]   off;
    logic [TW-1:0] dest;
    int unsigned   seq;
  } ment_t;

  ment_t         m [DEPTH];
  logic [OW-1:0] m_op;
  logic [31:0]   m_a, m_b, m_pc, m_off;
  logic [TW-1:0] m_dest;
  int unsigned   m_seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{default: '0};
    m_op = '0; m_a = '0; m_b = '0; m_pc = '0; m_off = '0; m_dest = '0;
    m_seq = 0;
  endfunction

  // Next state of the station given the inputs currently driven.
  function automatic void model_step();
    int sel, fr;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 0;
      m_op = '0;
      return;
    end
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && !m[i].jb && !m[i].kb) begin
`ifdef BRA_RS_OLDEST_FIRST_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v && fr < 0) fr = i;
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && m[i].jb && m[i].qj == cdb_tag) begin m[i].jb = 0; m[i].vj = cdb_value; end
        if (m[i].v && m[i].kb && m[i].qk == cdb_tag) begin m[i].kb = 0; m[i].vk = cdb_value; end
      end
    end
    if (sel >= 0) begin
      m_op = m[sel].op; m_a = m[sel].vj; m_b = m[sel].vk;
      m_pc = m[sel].pc; m_off = m[sel].off; m_dest = m[sel].dest;
      m[sel].v = 0;
    end else begin
      m_op = '0;
    end
    if (alloc_valid && fr >= 0) begin
      m[fr].v = 1; m[fr].op = alloc_op;
      m[fr].jb = alloc_qj_busy; m[fr].qj = alloc_qj; m[fr].vj = alloc_vj;
      m[fr].kb = alloc_qk_busy; m[fr].qk = alloc_qk; m[fr].vk = alloc_vk;
      if (cdb_valid && alloc_qj_busy && alloc_qj == cdb_tag) begin m[fr].jb = 0; m[fr].vj = cdb_value; end
      if (cdb_valid && alloc_qk_busy && alloc_qk == cdb_tag) begin m[fr].kb = 0; m[fr].vk = cdb_value; end
      m[fr].pc = alloc_pc; m[fr].off = alloc_offset; m[fr].dest = alloc_dest;
      m[fr].seq = m_seq;
      m_seq++;
    end
  endfunction

  task automatic check_model();
    bit any_free = 0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) any_free = 1;
    chk("alloc_ready", 32'(alloc_ready), 32'(any_free));
    chk("disp_op", 32'(disp_op), 32'(m_op));
    chk("disp_srca", disp_srca, m_a);
    chk("disp_srcb", disp_srcb, m_b);
    chk("disp_pc", disp_pc, m_pc);
    chk("disp_offset", disp_offset, m_off);
    chk("disp_dest", 32'(disp_dest), 32'(m_dest));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    alloc_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic set_alloc(input logic [OW-1:0] op, input bit jb, input logic [TW-1:0] qj,
                           input logic [31:0] vj, input bit kb, input logic [TW-1:0] qk,
                           input logic [31:0] vk, input logic [TW-1:0] dest);
    alloc_valid = 1; alloc_op = op;
    alloc_qj_busy = jb; alloc_qj = qj; alloc_vj = vj;
    alloc_qk_busy = kb; alloc_qk = qk; alloc_vk = vk;
    alloc_pc = 32'h1000 + 32'(dest) * 4; alloc_offset = 32'hFFFF_FFF0 + 32'(dest);
    alloc_dest = dest;
  endtask

  task automatic set_cdb(input logic [TW-1:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    chk("reset_op", 32'(disp_op), 32'd0);
    chk("reset_srca", disp_srca, 32'd0);
    chk("reset_pc", disp_pc, 32'd0);
    chk("reset_dest", 32'(disp_dest), 32'd0);
    rst_n = 1;

    // Ready BEQ dispatches two edges after being presented, for one cycle.
    set_alloc(`BEQ, 0, 0, 5, 0, 0, 5, 3);
    cycle(); idle();
    cycle();
    chk("beq_op", 32'(disp_op), 32'(`BEQ));
    chk("beq_srca", disp_srca, 32'd5);
    chk("beq_srcb", disp_srcb, 32'd5);
    chk("beq_dest", 32'(disp_dest), 32'd3);
    cycle();
    chk("beq_then_idle", 32'(disp_op), 32'd0);

    // BNE waits on tag 7, woken by a broadcast.
    set_alloc(`BNE, 1, 7, 0, 0, 0, 9, 4);
    cycle(); idle();
    cycle();
    chk("bne_waiting", 32'(disp_op), 32'd0);
    set_cdb(7, 32'h10);
    cycle(); idle();
    chk("bne_wake_edge", 32'(disp_op), 32'd0);
    cycle();
    chk("bne_op", 32'(disp_op), 32'(`BNE));
    chk("bne_srca", disp_srca, 32'h10);
    cycle();

    // Allocate-time bypass on operand B.
    set_alloc(`BLT, 0, 0, 1, 1, 2, 0, 6);
    set_cdb(2, 32'h77);
    cycle(); idle();
    cycle();
    chk("bypass_op", 32'(disp_op), 32'(`BLT));
    chk("bypass_srcb", disp_srcb, 32'h77);
    cycle();

    // Fill all slots with waiting entries, then overflow.
    for (int t = 0; t < DEPTH; t++) begin
      set_alloc(`BGE, 1, TW'(8 + t), 0, 0, 0, 32'(t), TW'(t));
      cycle();
    end
    chk("full_ready", 32'(alloc_ready), 32'd0);
    set_alloc(`BGE, 1, 13, 0, 0, 0, 0, 9);
    cycle(); idle();
    chk("dropped_ready", 32'(alloc_ready), 32'd0);
    set_cdb(9, 32'hAA);
    cycle(); idle();
    chk("full_wake_edge", 32'(disp_op), 32'd0);
    cycle();
    chk("full_disp_op", 32'(disp_op), 32'(`BGE));
    chk("full_disp_dest", 32'(disp_dest), 32'd1);
    chk("full_ready_after", 32'(alloc_ready), 32'd1);
    set_cdb(8, 32'h1); cycle();
    set_cdb(10, 32'h2); cycle();
    set_cdb(11, 32'h3); cycle();
    idle();
    repeat (4) cycle();
    chk("drained_op", 32'(disp_op), 32'd0);

    // Age ordering: B in slot 1 is older than C in slot 0.
    set_alloc(`JAL, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    set_alloc(`BEQ, 1, 4, 0, 1, 4, 0, 5);
    cycle();
    chk("age_a_op", 32'(disp_op), 32'(`JAL));
    set_alloc(`BNE, 1, 4, 0, 0, 0, 0, 2);
    cycle(); idle();
    set_cdb(4, 32'h44);
    cycle(); idle();
    cycle();
`ifdef BRA_RS_OLDEST_FIRST_EN
    chk("age_first_dest", 32'(disp_dest), 32'd5);
    cycle();
    chk("age_second_dest", 32'(disp_dest), 32'd2);
`else
    chk("age_first_dest", 32'(disp_dest), 32'd2);
    cycle();
    chk("age_second_dest", 32'(disp_dest), 32'd5);
`endif
    cycle();

    // Flush with a ready entry and a simultaneous allocation.
    set_alloc(`BLTU, 0, 0, 3, 0, 0, 4, 7);
    cycle();
    set_alloc(`BGEU, 0, 0, 1, 0, 0, 2, 8);
    flush = 1;
    cycle(); idle();
    chk("flush_op", 32'(disp_op), 32'd0);
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    cycle();
    chk("flush_op_next", 32'(disp_op), 32'd0);

    // Asynchronous reset between edges.
    set_alloc(`JALR, 1, 3, 0, 0, 0, 0, 10);
    cycle();
    set_alloc(`BGEU, 0, 0, 32'h55, 0, 0, 32'h66, 11);
    cycle(); idle();
    cycle();
    #2 rst_n = 0;
    #1;
    chk("async_rst_ready", 32'(alloc_ready), 32'd1);
    chk("async_rst_op", 32'(disp_op), 32'd0);
    chk("async_rst_srca", disp_srca, 32'd0);
    chk("async_rst_dest", 32'(disp_dest), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_op = OW'($urandom_range(1, 8));
      alloc_qj_busy = 1'($urandom_range(0, 1));
      alloc_qk_busy = 1'($urandom_range(0, 1));
      if (alloc_op == `JAL) begin alloc_qj_busy = 0; alloc_qk_busy = 0; end
      if (alloc_op == `JALR) alloc_qk_busy = 0;
      alloc_qj = TW'($urandom_range(0, 7));
      alloc_qk = TW'($urandom_range(0, 7));
      alloc_vj = $urandom; alloc_vk = $urandom;
      alloc_pc = $urandom; alloc_offset = $urandom;
      alloc_dest = TW'($urandom_range(0, 15));
      cdb_valid = ($urandom_range(0, 2) != 0);
      cdb_tag = TW'($urandom_range(0, 7));
      cdb_value = $urandom;
      flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
